// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK/DON'T-WALK controller slaved to the vehicle light; grants walk only on a red edge.
// Latency: all outputs registered, walk rises one edge after red_edge && request; no backpressure.
// Backpressure: none; requests are latched in req_pending until the next eligible red edge.
module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int CNT_W        = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       light,
  input  logic             ped_req,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic             light_err
);

  localparam int WC_W = (WALK_CYCLES > 1) ? $clog2(WALK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WALK, FLASH, HOLD} state_t;

  state_t           state_q, state_d;
  logic             red_q, red_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic [CNT_W-1:0] countdown_q, countdown_d;
  logic             req_pending_q, req_pending_d;
  logic             light_err_q, light_err_d;

  logic is_red, illegal, red_edge, req_any;

  assign is_red   = (light == 3'b100);
  assign illegal  = !((light == 3'b100) || (light == 3'b010) || (light == 3'b001));
  assign red_edge = is_red && !red_q;
  assign req_any  = req_pending_q | ped_req;

  always_comb begin
    state_d       = state_q;
    red_d         = is_red;
    wcnt_d        = wcnt_q;
    walk_d        = 1'b0;
    dont_walk_d   = 1'b1;
    countdown_d   = '0;
    req_pending_d = req_pending_q;
    light_err_d   = illegal;

    // Illegal codes force a safe IDLE and freeze the pending request.
    if (illegal) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (red_edge && req_any) begin
            state_d       = WALK;
            req_pending_d = 1'b0;
            walk_d        = 1'b1;
            dont_walk_d   = 1'b0;
            wcnt_d        = WC_W'(WALK_CYCLES - 1);
          end else begin
            req_pending_d = req_any;
          end
        end
        WALK: begin
          if (!is_red) begin
            state_d = IDLE;
          end else if (wcnt_q == '0) begin
            state_d     = FLASH;
            countdown_d = CNT_W'(FLASH_CYCLES - 1);
          end else begin
            wcnt_d      = wcnt_q - 1'b1;
            walk_d      = 1'b1;
            dont_walk_d = 1'b0;
          end
        end
        FLASH: begin
          if (!is_red) begin
            state_d = IDLE;
          end else begin
            req_pending_d = req_any;
            if (countdown_q == '0) begin
              state_d = HOLD;
            end else begin
              countdown_d = countdown_q - 1'b1;
              dont_walk_d = ~dont_walk_q;
            end
          end
        end
        HOLD: begin
          req_pending_d = req_any;
          if (!is_red) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      red_q         <= 1'b1;
      wcnt_q        <= '0;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      countdown_q   <= '0;
      req_pending_q <= 1'b0;
      light_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      red_q         <= red_d;
      wcnt_q        <= wcnt_d;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      countdown_q   <= countdown_d;
      req_pending_q <= req_pending_d;
      light_err_q   <= light_err_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign countdown   = countdown_q;
  assign req_pending = req_pending_q;
  assign light_err   = light_err_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl: driver queues expected post-edge outputs, monitor pops and compares.
module tb_ped_signal_ctrl;

  localparam int CNT_W = 4;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct packed {
    logic             w;
    logic             dw;
    logic [CNT_W-1:0] cd;
    logic             rp;
    logic             le;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [2:0]       light;
  logic             ped_req;
  logic             walk, dont_walk, req_pending, light_err;
  logic [CNT_W-1:0] countdown;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  ped_signal_ctrl #(.WALK_CYCLES(8), .FLASH_CYCLES(6), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .light       (light),
    .ped_req     (ped_req),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .light_err   (light_err)
  );

  always #5 clock = ~clock;

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clock) begin
    exp_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{w: walk, dw: dont_walk, cd: countdown, rp: req_pending, le: light_err};
      vectors++;
      if (a !== e || (walk && dont_walk)) begin
        miscompares++;
        $display("FAIL vec%0d: got walk=%b dont_walk=%b countdown=%0d req_pending=%b light_err=%b, want walk=%b dont_walk=%b countdown=%0d req_pending=%b light_err=%b",
                 vectors, a.w, a.dw, a.cd, a.rp, a.le, e.w, e.dw, e.cd, e.rp, e.le);
      end
    end
  end

  task automatic step(input logic rn, input logic [2:0] l, input logic rq,
                      input logic w, input logic dw, input int cd,
                      input logic rp, input logic le);
    exp_t e;
    @(negedge clock);
    reset_n = rn;
    light   = l;
    ped_req = rq;
    e = '{w: w, dw: dw, cd: CNT_W'(cd), rp: rp, le: le};
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0;
    light   = R;
    ped_req = 1'b0;

    // Reset, then release under a standing red: no grant.
    repeat (2)  step(0, R, 0, 0, 1, 0, 0, 0);
    repeat (20) step(1, R, 0, 0, 1, 0, 0, 0);

    // Normal grant from a latched pulse.
    step(1, G, 0, 0, 1, 0, 0, 0);
    step(1, G, 1, 0, 1, 0, 1, 0);
    step(1, G, 0, 0, 1, 0, 1, 0);
    step(1, Y, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, R, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, R, 0, 0, (i % 2) == 0, 5 - i, 0, 0);
    repeat (3) step(1, R, 0, 0, 1, 0, 0, 0);

    // Red edge without any request.
    step(1, G, 0, 0, 1, 0, 0, 0);
    step(1, Y, 0, 0, 1, 0, 0, 0);
    repeat (4) step(1, R, 0, 0, 1, 0, 0, 0);

    // Simultaneous request and red edge; requests during WALK ignored, during FLASH latched.
    step(1, G, 0, 0, 1, 0, 0, 0);
    step(1, Y, 0, 0, 1, 0, 0, 0);
    step(1, R, 1, 1, 0, 0, 0, 0);
    repeat (7) step(1, R, 1, 1, 0, 0, 0, 0);
    step(1, R, 0, 0, 1, 5, 0, 0);
    step(1, R, 1, 0, 0, 4, 1, 0);
    for (int i = 2; i < 6; i++) step(1, R, 0, 0, (i % 2) == 0, 5 - i, 1, 0);
    repeat (3) step(1, R, 0, 0, 1, 0, 1, 0);
    step(1, Y, 0, 0, 1, 0, 1, 0);

    // Next red edge grants the latched request; abort on walk cycle 3.
    step(1, R, 0, 1, 0, 0, 0, 0);
    repeat (2) step(1, R, 0, 1, 0, 0, 0, 0);
    step(1, G, 0, 0, 1, 0, 0, 0);
    step(1, G, 0, 0, 1, 0, 0, 0);

    // Illegal code with a pending request held through it.
    step(1, G, 1, 0, 1, 0, 1, 0);
    repeat (3) step(1, 3'b011, 0, 0, 1, 0, 1, 1);
    step(1, G, 0, 0, 1, 0, 1, 0);
    step(1, Y, 0, 0, 1, 0, 1, 0);

    // Grant, then reset mid-FLASH at countdown=3 drops the pending request.
    step(1, R, 0, 1, 0, 0, 0, 0);
    repeat (7) step(1, R, 0, 1, 0, 0, 0, 0);
    step(1, R, 0, 0, 1, 5, 0, 0);
    step(1, R, 1, 0, 0, 4, 1, 0);
    step(1, R, 0, 0, 1, 3, 1, 0);
    step(0, R, 0, 0, 1, 0, 0, 0);
    repeat (6) step(1, R, 0, 0, 1, 0, 0, 0);

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
- Pedestrian crossing controller directly downstream of traffic_signals. It consumes the vehicle light code and drives the pedestrian WALK / DON'T-WALK heads.
- Latches push-button requests and grants a walk phase only at the start of a vehicle red. The walk phase is followed by a flashing don't-walk clearance with a countdown.
- Forces a safe solid don't-walk on any illegal or premature light change.

Parameters:
- WALK_CYCLES, 8, clock cycles walk is held high per grant (>=1)
- FLASH_CYCLES, 6, clock cycles of flashing clearance (>=2, <=2**CNT_W)
- CNT_W, 4, width of countdown output

Ports:
- clock  input  1  single system clock, all logic rising-edge
- reset_n  input  1  synchronous active-low reset
- light  input  3  vehicle light from traffic_signals, one-hot: 100=red, 010=yellow, 001=green
- ped_req  input  1  push-button, sampled every cycle (pulse or level)
- walk  output  1  walk head on
- dont_walk  output  1  don't-walk head on (solid or flashing)
- countdown  output  CNT_W  remaining flash cycles, 0 outside FLASH
- req_pending  output  1  request latched, awaiting next red
- light_err  output  1  light code not one of 100/010/001

Behaviour:
- Interface: one clock; reset is synchronous and active-low; ports are named clock and reset_n.
- All outputs are registered.
- Reset values (reset_n=0 at a clock edge): walk=0, dont_walk=1, countdown=0, req_pending=0, light_err=0, state=IDLE, red_q=1.
- red_q reset to 1 means a red already showing at reset release is not an edge.
- red_edge = (light==100) && !red_q; red_q <= (light==100) every cycle.
- req_any = req_pending | ped_req.
- States:
  - IDLE: walk=0, dont_walk=1. On red_edge && req_any -> WALK, req_pending<=0. Otherwise req_pending <= req_any.
  - WALK: walk=1, dont_walk=0, countdown=0. Internal counter runs WALK_CYCLES cycles -> FLASH. ped_req ignored (not latched).
  - FLASH: walk=0; dont_walk=1 on first FLASH cycle, toggling every cycle (1,0,1,0...). countdown = FLASH_CYCLES-1 on first cycle, decrementing to 0; after the countdown=0 cycle -> HOLD. ped_req latched into req_pending.
  - HOLD: walk=0, dont_walk=1 solid. -> IDLE when light!=100. ped_req latched. A second walk can never be granted within the same red.
- Latency: walk rises on the clock edge after the cycle in which red_edge && req_any is seen.
- A ped_req in the same cycle as red_edge is granted.
- Abort: in WALK or FLASH, if light!=100 -> next edge state=IDLE, walk=0, dont_walk=1 solid, countdown=0. req_pending is unchanged (it was already cleared at grant).
- Illegal code (not exactly one bit set): light_err=1 on the following edge and stays high while the code is illegal. Any state -> IDLE with dont_walk=1 solid. req_pending is held, and red_q is updated normally.
- Invariant: walk && dont_walk is never 1; walk=1 implies light was 100 in the previous cycle.
- reset_n low mid-operation overrides everything on that edge. A request pending at reset is lost.

Test Plan:
- Reset with light=100: reset_n=0 for 2 cycles, release with light held 100 for 20 cycles -> walk=0, dont_walk=1, countdown=0, req_pending=0 throughout.
- Normal grant (defaults): ped_req 1-cycle pulse during 001 -> req_pending=1 next cycle; then light 010, then 100 at cycle T.
  - walk=1 from T+1 to T+8.
  - dont_walk 1,0,1,0,1,0 with countdown 5,4,3,2,1,0 over T+9..T+14.
  - HOLD dont_walk=1 from T+15; req_pending=0.
- No request: red edge with ped_req=0 and req_pending=0 -> walk stays 0. ped_req during WALK -> req_pending=0 after the phase. ped_req during FLASH -> req_pending=1, and walk is granted only at the next red edge, not the current red.
- Simultaneous: ped_req=1 in the same cycle light goes 010->100 -> walk=1 next edge.
- Abort/illegal:
  - light->001 on WALK cycle 3 -> next edge walk=0, dont_walk=1, countdown=0, state IDLE.
  - light=011 for 3 cycles -> light_err=1 for 3 cycles (one-cycle lag), dont_walk=1 solid.
- Reset mid-FLASH: reset_n=0 at countdown=3 -> next edge all outputs at reset values. The red still present at release does not grant a walk.
